// File: rtl/cache_mem_arbiter_if.sv
// Bundle of cache-side and memory-side signals around the cache/memory arbiter.
//
// Handshake: a cache holds its request level (icache_read, or dcache_read /
// dcache_write) until the matching *_resp pulses high for exactly one cycle;
// *_rdata is meaningful only while that resp is high. Memory sees mem_read /
// mem_write held level for the whole transaction and ends it with a
// one-cycle mem_resp; there is no separate ready, so a request is accepted
// by the arbiter simply by being seen while it is idle.
interface cache_mem_arbiter_if;
  logic         icache_read;
  logic [31:0]  icache_address;
  logic         icache_resp;
  logic [255:0] icache_rdata;
  logic         dcache_read;
  logic         dcache_write;
  logic [31:0]  dcache_address;
  logic [255:0] dcache_wdata;
  logic         dcache_resp;
  logic [255:0] dcache_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  // Environment view: both caches and the memory.
  modport master (
    output icache_read, icache_address,
    input  icache_resp, icache_rdata,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_resp, dcache_rdata,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

  // Arbiter view.
  modport slave (
    input  icache_read, icache_address,
    output icache_resp, icache_rdata,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_resp, dcache_rdata,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one burst memory port between the icache and dcache miss paths.
// One whole-line transaction at a time; the winning request is captured at
// grant so later changes on the cache side cannot disturb the memory side.
module cache_mem_arbiter #(
  parameter int DCACHE_PRIO = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic                clk,
  input  logic                rst,
  cache_mem_arbiter_if.slave  bus,
  output logic [1:0]          dbg_state,
  output logic [3:0]          dbg_wait_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } state_e;

  localparam logic       GRANT_I    = 1'b0;
  localparam logic       GRANT_D    = 1'b1;
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          req_write_q, req_write_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [255:0]  req_wdata_q, req_wdata_d;
  logic          i_req, d_req, pick_d;

  // Low address bits are line offsets and never reach memory.
  logic unused_offsets;
  assign unused_offsets = ^{bus.icache_address[4:0], bus.dcache_address[4:0]};

  assign dbg_state    = state_q;
  assign dbg_wait_cnt = wait_cnt_q;

  // State, arbitration history and captured request; cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      wait_cnt_q   <= 4'd0;
      req_write_q  <= 1'b0;
      req_addr_q   <= 32'd0;
      req_wdata_q  <= 256'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      req_write_q  <= req_write_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
    end
  end

  // Arbitration, request capture, memory drive and response routing.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    wait_cnt_d       = wait_cnt_q;
    req_write_d      = req_write_q;
    req_addr_d       = req_addr_q;
    req_wdata_d      = req_wdata_q;
    i_req            = bus.icache_read;
    d_req            = bus.dcache_read | bus.dcache_write;
    pick_d           = 1'b0;
    bus.icache_resp  = 1'b0;
    bus.icache_rdata = 256'd0;
    bus.dcache_resp  = 1'b0;
    bus.dcache_rdata = 256'd0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_address  = 32'd0;
    bus.mem_wdata    = 256'd0;

    case (state_q)
      IDLE: begin
        // Starvation guard overrides both fixed priority and round-robin.
        if (i_req && d_req) begin
          if (wait_cnt_q >= MAX_WAIT_C)  pick_d = 1'b0;
          else if (DCACHE_PRIO != 0)     pick_d = 1'b1;
          else                           pick_d = (last_grant_q == GRANT_I);
        end else begin
          pick_d = d_req;
        end

        if (i_req || d_req) begin
          last_grant_d = pick_d;
          if (pick_d) begin
            state_d     = SERVE_D;
            req_write_d = bus.dcache_write;
            req_addr_d  = {bus.dcache_address[31:5], 5'b0};
            req_wdata_d = bus.dcache_wdata;
            // Only count losses the icache actually suffered.
            if (i_req && (wait_cnt_q != 4'hf)) wait_cnt_d = wait_cnt_q + 4'd1;
          end else begin
            state_d     = SERVE_I;
            req_write_d = 1'b0;
            req_addr_d  = {bus.icache_address[31:5], 5'b0};
            req_wdata_d = 256'd0;
            wait_cnt_d  = 4'd0;
          end
        end
      end

      SERVE_I, SERVE_D: begin
        bus.mem_read    = ~req_write_q;
        bus.mem_write   = req_write_q;
        bus.mem_address = req_addr_q;
        bus.mem_wdata   = req_wdata_q;
        if (bus.mem_resp) begin
          state_d = RECOVER;
          if (state_q == SERVE_I) begin
            bus.icache_resp  = 1'b1;
            bus.icache_rdata = bus.mem_rdata;
          end else begin
            bus.dcache_resp  = 1'b1;
            bus.dcache_rdata = bus.mem_rdata;
          end
        end
      end

      // Dead cycle so the served cache can drop its request before re-arbitration.
      RECOVER: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: vector table, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_cache_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state, rr_dbg_state;
  logic [3:0] dbg_wait_cnt, rr_dbg_wait_cnt;
  int         errors = 0;
  int         checks = 0;

  cache_mem_arbiter_if bus();
  cache_mem_arbiter_if bus_rr();

  cache_mem_arbiter #(.DCACHE_PRIO(1), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst_n), .bus(bus.slave),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  cache_mem_arbiter #(.DCACHE_PRIO(0), .MAX_WAIT(4)) dut_rr (
    .clk(clk), .rst(rst_n), .bus(bus_rr.slave),
    .dbg_state(rr_dbg_state), .dbg_wait_cnt(rr_dbg_wait_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic clear_inputs();
    bus.icache_read = 0; bus.icache_address = 0;
    bus.dcache_read = 0; bus.dcache_write = 0; bus.dcache_address = 0; bus.dcache_wdata = 0;
    bus.mem_rdata = 0; bus.mem_resp = 0;
    bus_rr.icache_read = 0; bus_rr.icache_address = 0;
    bus_rr.dcache_read = 0; bus_rr.dcache_write = 0; bus_rr.dcache_address = 0; bus_rr.dcache_wdata = 0;
    bus_rr.mem_rdata = 0; bus_rr.mem_resp = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_read"},  bus.mem_read, 1'b0);
    check({tag, "_mem_write"}, bus.mem_write, 1'b0);
    check({tag, "_mem_addr"},  bus.mem_address, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 256'd0);
    check({tag, "_i_resp"},    bus.icache_resp, 1'b0);
    check({tag, "_i_rdata"},   bus.icache_rdata, 256'd0);
    check({tag, "_d_resp"},    bus.dcache_resp, 1'b0);
    check({tag, "_d_rdata"},   bus.dcache_rdata, 256'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr; logic dw; logic [31:0] da; logic [255:0] dwd;
    logic mr; logic [255:0] mrd;
    logic e_rd; logic e_wr; logic [31:0] e_ma; logic [255:0] e_wd;
    logic e_ir; logic e_dr;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  // ---------------- scoreboard / reference model ----------------
  logic [31:0] exp_q[$];
  int          m_owner;   // 0 none, 1 icache, 2 dcache
  bit          m_rec;
  int          m_wait;
  logic        m_write;
  logic [31:0] m_addr;
  logic [255:0] m_wdata;

  // Winner for the dcache-priority arbiter with a starvation limit of 4.
  function automatic int model_pick(bit ir, bit dr);
    if (ir && dr) return (m_wait >= 4) ? 1 : 2;
    return ir ? 1 : 2;
  endfunction

  initial begin
    logic [255:0] a5, c3, wd, r;
    logic [255:0] e_ird, e_drd;
    bit in_txn, srv, seen;
    bit s_ir_resp, s_dr_resp, s_mreq, s_mresp;
    int mem_lat, w;

    a5 = {32{8'hA5}};
    c3 = {32{8'hC3}};
    wd = {8{32'hDEADBEEF}};

    // Reset state: outputs zero with no clock edge needed.
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check_all_zero("reset");
    check("reset_wait_cnt", dbg_wait_cnt, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    //            ir ia       dr dw da        dwd  mr mrd  e_rd e_wr e_ma     e_wd e_ir e_dr
    vecs[0]  = '{1, 32'h1234, 0, 0, 32'h0,    0,   0, 0,   0,   0,   32'h0,    0,   0,   0};
    vecs[1]  = '{1, 32'h1234, 0, 0, 32'h0,    0,   0, 0,   1,   0,   32'h1220, 0,   0,   0};
    vecs[2]  = '{1, 32'h1234, 0, 0, 32'h0,    0,   1, a5,  1,   0,   32'h1220, 0,   1,   0};
    vecs[3]  = '{0, 32'h0,    0, 0, 32'h0,    0,   0, 0,   0,   0,   32'h0,    0,   0,   0};
    vecs[4]  = '{0, 32'h0,    0, 0, 32'h0,    0,   1, a5,  0,   0,   32'h0,    0,   0,   0};
    vecs[5]  = '{1, 32'h100,  0, 1, 32'h2041, wd,  0, 0,   0,   0,   32'h0,    0,   0,   0};
    vecs[6]  = '{1, 32'h100,  0, 1, 32'h2041, wd,  0, 0,   0,   1,   32'h2040, wd,  0,   0};
    vecs[7]  = '{1, 32'h100,  0, 1, 32'h2041, wd,  1, c3,  0,   1,   32'h2040, wd,  0,   1};
    vecs[8]  = '{1, 32'h100,  0, 0, 32'h0,    0,   1, a5,  0,   0,   32'h0,    0,   0,   0};
    vecs[9]  = '{1, 32'h100,  0, 0, 32'h0,    0,   0, 0,   0,   0,   32'h0,    0,   0,   0};
    vecs[10] = '{1, 32'h100,  0, 0, 32'h0,    0,   0, 0,   1,   0,   32'h100,  0,   0,   0};
    vecs[11] = '{1, 32'h100,  0, 0, 32'h0,    0,   1, c3,  1,   0,   32'h100,  0,   1,   0};
    vecs[12] = '{0, 32'h0,    0, 0, 32'h0,    0,   0, 0,   0,   0,   32'h0,    0,   0,   0};
    vecs[13] = '{0, 32'h0,    0, 0, 32'h0,    0,   0, 0,   0,   0,   32'h0,    0,   0,   0};

    for (int i = 0; i < NV; i++) begin
      tick();
      bus.icache_read = vecs[i].ir; bus.icache_address = vecs[i].ia;
      bus.dcache_read = vecs[i].dr; bus.dcache_write = vecs[i].dw;
      bus.dcache_address = vecs[i].da; bus.dcache_wdata = vecs[i].dwd;
      bus.mem_resp = vecs[i].mr; bus.mem_rdata = vecs[i].mrd;
      @(negedge clk);
      e_ird = vecs[i].e_ir ? vecs[i].mrd : 256'd0;
      e_drd = vecs[i].e_dr ? vecs[i].mrd : 256'd0;
      check($sformatf("v%0d_mem_read", i),  bus.mem_read, vecs[i].e_rd);
      check($sformatf("v%0d_mem_write", i), bus.mem_write, vecs[i].e_wr);
      check($sformatf("v%0d_mem_addr", i),  bus.mem_address, vecs[i].e_ma);
      check($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vecs[i].e_wd);
      check($sformatf("v%0d_i_resp", i),    bus.icache_resp, vecs[i].e_ir);
      check($sformatf("v%0d_i_rdata", i),   bus.icache_rdata, e_ird);
      check($sformatf("v%0d_d_resp", i),    bus.dcache_resp, vecs[i].e_dr);
      check($sformatf("v%0d_d_rdata", i),   bus.dcache_rdata, e_drd);
    end

    // Abort/instability: dcache moves its address and drops its request after grant.
    tick();
    bus.dcache_read = 1; bus.dcache_address = 32'h3000_0047;
    @(negedge clk);
    check("abort_latency", bus.mem_read, 1'b0);
    tick();
    bus.dcache_read = 0; bus.dcache_address = 32'hFFFF_FFE0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_mem_read", bus.mem_read, 1'b1);
      check("abort_mem_addr", bus.mem_address, 32'h3000_0040);
      check("abort_d_resp_early", bus.dcache_resp, 1'b0);
      tick();
    end
    r = rand256();
    bus.mem_resp = 1; bus.mem_rdata = r;
    @(negedge clk);
    check("abort_d_resp", bus.dcache_resp, 1'b1);
    check("abort_d_rdata", bus.dcache_rdata, r);
    check("abort_i_resp", bus.icache_resp, 1'b0);
    check("abort_i_rdata", bus.icache_rdata, 256'd0);
    tick();
    bus.mem_resp = 0;
    @(negedge clk);
    check("abort_recover_resp", bus.dcache_resp, 1'b0);
    check("abort_recover_req", bus.mem_read, 1'b0);
    tick();
    @(negedge clk);
    check("abort_no_regrant", bus.mem_read | bus.mem_write, 1'b0);

    // Starvation guard: four dcache wins, then the icache is forced through.
    tick();
    bus.icache_read = 1; bus.icache_address = 32'h5000;
    bus.dcache_read = 1; bus.dcache_address = 32'h6000;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h6000);
    exp_q.push_back(32'h5000);
    in_txn = 0;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      srv = bus.mem_read | bus.mem_write;
      if (srv && !in_txn) begin
        in_txn = 1;
        check("starve_grant", bus.mem_address, exp_q.pop_front());
      end
      tick();
      if (bus.mem_resp) begin bus.mem_resp = 0; in_txn = 0; end
      else if (srv) bus.mem_resp = 1;
    end
    check("starve_all_grants", exp_q.size(), 0);
    @(negedge clk);
    check("starve_i_resp", bus.icache_resp, 1'b1);
    check("starve_wait_clear", dbg_wait_cnt, 4'd0);
    tick();
    bus.mem_resp = 0; bus.icache_read = 0; bus.dcache_read = 0;
    repeat (2) tick();

    // Reset during a dcache write-back.
    bus.dcache_write = 1; bus.dcache_address = 32'h7000; bus.dcache_wdata = wd;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = bus.mem_write;
      if (!seen) tick();
    end
    check("rst_pre_write", seen, 1'b1);
    rst_n = 1'b0;
    bus.mem_resp = 1; bus.mem_rdata = a5;
    #1;
    check_all_zero("rst_mid");
    clear_inputs();
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      check("rst_after_idle", bus.mem_read | bus.mem_write, 1'b0);
    end
    check("rst_after_wait", dbg_wait_cnt, 4'd0);
    tick();
    bus.icache_read = 1; bus.icache_address = 32'h8000;
    @(negedge clk);
    check("rst_new_latency", bus.mem_read, 1'b0);
    tick();
    @(negedge clk);
    check("rst_new_read", bus.mem_read, 1'b1);
    check("rst_new_addr", bus.mem_address, 32'h8000);
    tick();
    bus.mem_resp = 1; bus.mem_rdata = c3;
    @(negedge clk);
    check("rst_new_resp", bus.icache_resp, 1'b1);
    tick();
    bus.mem_resp = 0; bus.icache_read = 0;
    repeat (2) tick();

    // Round-robin instance: continuous ties alternate I, D, I, D.
    bus_rr.icache_read = 1; bus_rr.icache_address = 32'h1000;
    bus_rr.dcache_read = 1; bus_rr.dcache_address = 32'h2000;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(32'h1000);
      exp_q.push_back(32'h2000);
    end
    in_txn = 0;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      srv = bus_rr.mem_read | bus_rr.mem_write;
      if (srv && !in_txn) begin
        in_txn = 1;
        check("rr_grant", bus_rr.mem_address, exp_q.pop_front());
      end
      tick();
      if (bus_rr.mem_resp) begin bus_rr.mem_resp = 0; in_txn = 0; end
      else if (srv) bus_rr.mem_resp = 1;
    end
    check("rr_all_grants", exp_q.size(), 0);
    tick();
    bus_rr.mem_resp = 0; bus_rr.icache_read = 0; bus_rr.dcache_read = 0;
    repeat (2) tick();

    // Random traffic against the reference model, starting from a fresh reset.
    @(negedge clk) rst_n = 1'b0;
    clear_inputs();
    @(negedge clk) rst_n = 1'b1;
    m_owner = 0; m_rec = 0; m_wait = 0; m_write = 0; m_addr = 0; m_wdata = 0;
    mem_lat = -1;
    s_ir_resp = 0; s_dr_resp = 0; s_mreq = 0; s_mresp = 0;
    for (int c = 0; c < 500; c++) begin
      tick();
      // Memory responder.
      if (bus.mem_resp) begin
        bus.mem_resp = 0;
      end else begin
        if (mem_lat < 0 && s_mreq && !s_mresp) mem_lat = $urandom_range(0, 3);
        if (mem_lat == 0) begin
          bus.mem_resp = 1; bus.mem_rdata = rand256(); mem_lat = -1;
        end else if (mem_lat > 0) begin
          mem_lat--;
        end else if ($urandom_range(0, 15) == 0) begin
          bus.mem_resp = 1; bus.mem_rdata = rand256();
        end
      end
      // Caches: hold until resp, drop right after, sometimes wobble the address.
      if (s_ir_resp) bus.icache_read = 0;
      else if (!bus.icache_read && $urandom_range(0, 3) == 0) begin
        bus.icache_read = 1; bus.icache_address = $urandom();
      end else if (bus.icache_read && $urandom_range(0, 7) == 0) bus.icache_address = $urandom();
      if (s_dr_resp) begin bus.dcache_read = 0; bus.dcache_write = 0; end
      else if (!(bus.dcache_read | bus.dcache_write) && $urandom_range(0, 2) == 0) begin
        w = $urandom_range(0, 1);
        bus.dcache_read = (w == 0); bus.dcache_write = (w == 1);
        bus.dcache_address = $urandom(); bus.dcache_wdata = rand256();
      end else if ((bus.dcache_read | bus.dcache_write) && $urandom_range(0, 7) == 0) begin
        bus.dcache_address = $urandom(); bus.dcache_wdata = rand256();
      end

      @(negedge clk);
      e_ird = (m_owner == 1 && bus.mem_resp) ? bus.mem_rdata : 256'd0;
      e_drd = (m_owner == 2 && bus.mem_resp) ? bus.mem_rdata : 256'd0;
      check("rnd_mem_read",  bus.mem_read,  (m_owner != 0) && !m_write);
      check("rnd_mem_write", bus.mem_write, (m_owner != 0) && m_write);
      check("rnd_mem_addr",  bus.mem_address, (m_owner != 0) ? m_addr : 32'd0);
      check("rnd_mem_wdata", bus.mem_wdata, (m_owner != 0) ? m_wdata : 256'd0);
      check("rnd_i_resp",    bus.icache_resp, (m_owner == 1) && bus.mem_resp);
      check("rnd_i_rdata",   bus.icache_rdata, e_ird);
      check("rnd_d_resp",    bus.dcache_resp, (m_owner == 2) && bus.mem_resp);
      check("rnd_d_rdata",   bus.dcache_rdata, e_drd);
      check("rnd_wait_cnt",  dbg_wait_cnt, 4'(m_wait));
      s_ir_resp = bus.icache_resp; s_dr_resp = bus.dcache_resp;
      s_mreq = bus.mem_read | bus.mem_write; s_mresp = bus.mem_resp;

      // Transaction-level model advance for the coming edge.
      if (m_rec) begin
        m_rec = 0;
      end else if (m_owner != 0) begin
        if (bus.mem_resp) begin m_owner = 0; m_rec = 1; end
      end else if (bus.icache_read || bus.dcache_read || bus.dcache_write) begin
        m_owner = model_pick(bus.icache_read, bus.dcache_read | bus.dcache_write);
        if (m_owner == 1) begin
          m_write = 0; m_addr = {bus.icache_address[31:5], 5'b0}; m_wdata = 0; m_wait = 0;
        end else begin
          m_write = bus.dcache_write; m_addr = {bus.dcache_address[31:5], 5'b0};
          m_wdata = bus.dcache_wdata;
          if (bus.icache_read && m_wait < 15) m_wait = m_wait + 1;
        end
      end
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
